// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one Y86 pipeline stage register carrying status, icode
// and a packed payload. It supports stall (hold), bubble (inject a nop) and
// an exception freeze that keeps a non-AOK instruction in place until reset.
// Optional feature macro: PIPE_STATS_EN adds saturating stall and bubble
// counters. Without it, both counter ports read as zero.
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W     = 256,
    parameter logic [3:0]  BUBBLE_ICODE  = 4'h1,
    parameter bit          FREEZE_ON_EXC = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           in_status,
    input  logic [3:0]           in_icode,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 stall,
    input  logic                 bubble,
    output logic [2:0]           out_status,
    output logic [3:0]           out_icode,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    output logic                 frozen,
    output logic                 ctl_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [2:0] ST_AOK = 3'b001;
    localparam logic [2:0] ST_INS = 3'b010;
    localparam logic [2:0] ST_HLT = 3'b100;

    typedef enum logic [1:0] {
        ACT_FROZEN,
        ACT_STALL,
        ACT_BUBBLE,
        ACT_LOAD
    } action_e;

    // Anything that is not a legal one-hot status is treated as an illegal
    // instruction so the exception still propagates down the pipe.
    function automatic logic [2:0] norm_status(input logic [2:0] s);
        case (s)
            ST_AOK, ST_INS, ST_HLT: return s;
            default:                return ST_INS;
        endcase
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [2:0]           status_q,  status_d;
    logic [3:0]           icode_q,   icode_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 valid_q,   valid_d;
    logic                 err_q,     err_d;
    logic                 frozen_w;
    action_e              action;

    assign frozen_w = FREEZE_ON_EXC && (status_q != ST_AOK);

    // Select exactly one action per edge: freeze beats stall beats bubble.
    always_comb begin
        action = ACT_LOAD;
        if (frozen_w) begin
            action = ACT_FROZEN;
        end else if (stall) begin
            action = ACT_STALL;
        end else if (bubble) begin
            action = ACT_BUBBLE;
        end
    end

    // Next-state contents for the chosen action; frozen and stall both hold.
    always_comb begin
        status_d  = status_q;
        icode_d   = icode_q;
        payload_d = payload_q;
        valid_d   = valid_q;
        err_d     = err_q;
        case (action)
            ACT_STALL: begin
                // Conflicting hazard-unit request; stall still wins.
                if (bubble) begin
                    err_d = 1'b1;
                end
            end
            ACT_BUBBLE: begin
                status_d  = ST_AOK;
                icode_d   = BUBBLE_ICODE;
                payload_d = '0;
                valid_d   = 1'b0;
            end
            ACT_LOAD: begin
                status_d  = norm_status(in_status);
                icode_d   = in_icode;
                payload_d = in_payload;
                valid_d   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Stage contents and sticky control-error flag, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q  <= ST_AOK;
            icode_q   <= BUBBLE_ICODE;
            payload_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            status_q  <= status_d;
            icode_q   <= icode_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Count stall and bubble actions; frozen cycles are not counted.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (action == ACT_STALL) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (action == ACT_BUBBLE) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

    assign out_status  = status_q;
    assign out_icode   = icode_q;
    assign out_payload = payload_q;
    assign out_valid   = valid_q;
    assign frozen      = frozen_w;
    assign ctl_err     = err_q;

endmodule
